// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
// Shares one 7x7 convolution engine between two pixel sources, one whole frame
// at a time, round-robin. Each frame is preceded by an engine clear. Input and
// result pixels are counted, results are forwarded with channel and last-pixel
// tags, and a drain watchdog ends a frame whose engine has gone silent.
module conv_frame_sequencer #(
    parameter int ROWS       = 7,
    parameter int COLS       = 7,
    parameter int D_BITS     = 8,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  i_clk,
    input  logic                  reset_n,
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_src_valid,
    input  logic [2*D_BITS-1:0]   i_src_data,
    output logic [1:0]            o_src_ready,
    output logic [1:0]            o_gnt,
    output logic                  o_eng_clr,
    output logic                  o_eng_drdy,
    output logic [D_BITS-1:0]     o_eng_data,
    input  logic                  i_eng_ready,
    input  logic                  i_eng_dvalid,
    input  logic [D_BITS-1:0]     i_eng_data,
    output logic                  o_pix_valid,
    output logic [D_BITS-1:0]     o_pix_data,
    output logic                  o_pix_ch,
    output logic                  o_pix_last,
    output logic                  o_done,
    output logic                  o_done_ch,
    output logic                  o_err
);

    localparam int IN_PIX  = ROWS * COLS;
    localparam int OUT_PIX = (ROWS - 6) * (COLS - 6);
    localparam int CNT_W   = $clog2(IN_PIX) + 1;
    localparam int WD_W    = $clog2(TIMEOUT) + 1;
    localparam int CLR_W   = $clog2(CLR_CYCLES) + 1;

    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_PIX - 1);
    localparam logic [CNT_W-1:0] OUT_FULL = CNT_W'(OUT_PIX);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_PIX - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_g;
    logic               r_rr;
    logic [1:0]         r_gnt;
    logic [CLR_W-1:0]   r_clr_cnt;
    logic [CNT_W-1:0]   r_in_cnt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic [WD_W-1:0]    r_wd_cnt;
    logic               r_err;
    logic               r_pix_valid;
    logic [D_BITS-1:0]  r_pix_data;
    logic               r_pix_ch;
    logic               r_pix_last;

    logic               w_grant;
    logic               w_pick;
    logic               w_drdy;
    logic               w_capture;
    logic               w_out_full;
    logic               w_wd_expire;
    logic [D_BITS-1:0]  w_src_sel;

    // Both requesting: honour the round-robin pointer; otherwise the lone requester.
    assign w_grant     = (r_state == S_IDLE) && (i_req != 2'b00);
    assign w_pick      = (i_req == 2'b11) ? r_rr : i_req[1];
    assign w_src_sel   = r_g ? i_src_data[D_BITS +: D_BITS] : i_src_data[0 +: D_BITS];
    assign w_drdy      = (r_state == S_STREAM) && i_src_valid[r_g] && i_eng_ready;
    assign w_capture   = ((r_state == S_STREAM) || (r_state == S_DRAIN)) &&
                         i_eng_dvalid && (r_out_cnt < OUT_FULL);
    // Counts the result arriving this cycle, so DONE lines up with o_pix_last.
    assign w_out_full  = (r_out_cnt == OUT_FULL) || (w_capture && (r_out_cnt == OUT_LAST));
    assign w_wd_expire = (r_wd_cnt == WD_LIMIT) && !i_eng_dvalid;

    // State register.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every register
            // samples pre-edge values regardless of block ordering.
            r_state <= w_next;
        end
    end

    // Next-state decode and the combinational engine/source handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_next      = r_state;
        o_src_ready = 2'b00;
        o_eng_drdy  = 1'b0;
        o_eng_data  = '0;
        o_eng_clr   = 1'b0;
        o_done      = 1'b0;
        o_done_ch   = 1'b0;
        o_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                o_eng_clr = 1'b1;
                if (r_clr_cnt == CLR_LAST) w_next = S_STREAM;
            end
            S_STREAM: begin
                o_src_ready[r_g] = i_eng_ready;
                o_eng_drdy       = w_drdy;
                o_eng_data       = w_src_sel;
                if (w_drdy && (r_in_cnt == IN_LAST)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_out_full || w_wd_expire) w_next = S_DONE;
            end
            S_DONE: begin
                o_done    = 1'b1;
                o_done_ch = r_g;
                o_err     = r_err;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Grant, channel latch and round-robin pointer.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_g   <= 1'b0;
            r_rr  <= 1'b0;
            r_gnt <= 2'b00;
        end else if (w_grant) begin
            r_g   <= w_pick;
            r_gnt <= w_pick ? 2'b10 : 2'b01;
        end else if (r_state == S_DONE) begin
            r_gnt <= 2'b00;
            r_rr  <= ~r_g;
        end
    end

    // Frame counters and watchdog; all restart at each grant.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_cnt <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_wd_cnt  <= '0;
            r_err     <= 1'b0;
        end else if (w_grant) begin
            r_clr_cnt <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_wd_cnt  <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
            if (w_drdy)             r_in_cnt  <= r_in_cnt + 1'b1;
            if (w_capture)          r_out_cnt <= r_out_cnt + 1'b1;
            if (i_eng_dvalid)               r_wd_cnt <= '0;
            else if (r_state == S_DRAIN)    r_wd_cnt <= r_wd_cnt + 1'b1;
            if ((r_state == S_DRAIN) && !w_out_full && w_wd_expire) r_err <= 1'b1;
        end
    end

    // Result forwarding register, one cycle behind i_eng_dvalid.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the data register is reset too so every output reads 0
            // during reset; this is a single word, not a memory array.
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_pix_ch    <= 1'b0;
            r_pix_last  <= 1'b0;
        end else begin
            r_pix_valid <= w_capture;
            if (w_capture) begin
                r_pix_data <= i_eng_data;
                r_pix_ch   <= r_g;
                r_pix_last <= (r_out_cnt == OUT_LAST);
            end else begin
                r_pix_last <= 1'b0;
            end
        end
    end

    assign o_gnt       = r_gnt;
    assign o_pix_valid = r_pix_valid;
    assign o_pix_data  = r_pix_data;
    assign o_pix_ch    = r_pix_ch;
    assign o_pix_last  = r_pix_last;

endmodule
